memory_mmio: RTL and testbench

Parametrised successor to the core's data memory. It provides a word-organised synchronous RAM, byte/halfword/word load/store per RISC-V funct3, N memory-mapped outports and M readable inports, a flash-load port, and sticky fault reporting. It sits between the core's load/store path and the board I/O.

---
 rtl/memory_mmio_pkg.sv | 23 ++
 rtl/memory_mmio_if.sv | 23 ++
 rtl/memory_mmio_mem_lane_align.sv | 55 +++++
 rtl/memory_mmio.sv | 157 +++++++++++++++
 tb/tb_memory_mmio.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_mmio_pkg.sv
// Shared types for the memory/MMIO block: access-size encodings, address regions
// and the IO map constants.
package memory_mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;
    localparam logic [7:0]  INPORT_OFFSET   = 8'h80;

    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_OUT,
        REGION_IN,
        REGION_NONE
    } region_t;

endpackage

// File: rtl/memory_mmio_if.sv
// Load/store/flash bus between the core and memory_mmio; the core is the master.
interface memory_mmio_if import memory_mmio_pkg::*; #(parameter int WIDTH = 32);

    logic             en;
    logic             wren;
    logic             flash_en;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wr_data;
    funct3_t          funct3;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output en, wren, flash_en, addr, wr_data, funct3,
        input  rd_data, rd_valid
    );

    modport slave (
        input  en, wren, flash_en, addr, wr_data, funct3,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/memory_mmio_mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// MEMORY_MMIO_MISALIGN_FAULT_EN: flag misaligned half/word accesses instead of aligning them.
module mem_lane_align import memory_mmio_pkg::*; (
    input  funct3_t     funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_lanes,
    output logic [31:0] rd_ext,
    output logic        fn_bad,
    output logic        misalign_fault
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = wr_data;
        rd_ext   = '0;
        fn_bad   = 1'b0;
        sel_byte = rd_word[{offset, 3'b000} +: 8];
        // Half accesses only look at offset[1]; offset[0] is either faulted or dropped.
        sel_half = offset[1] ? rd_word[31:16] : rd_word[15:0];

        case (funct3)
            BYTE, BYTE_U: begin
                byte_en  = 4'b0001 << offset;
                wr_lanes = {4{wr_data[7:0]}};
                rd_ext   = (funct3 == BYTE) ? {{24{sel_byte[7]}}, sel_byte}
                                            : {24'h0, sel_byte};
            end
            HALF, HALF_U: begin
                byte_en  = offset[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wr_data[15:0]}};
                rd_ext   = (funct3 == HALF) ? {{16{sel_half[15]}}, sel_half}
                                            : {16'h0, sel_half};
            end
            WORD: begin
                byte_en = 4'b1111;
                rd_ext  = rd_word;
            end
            default: fn_bad = 1'b1;
        endcase

`ifdef MEMORY_MMIO_MISALIGN_FAULT_EN
        misalign_fault = (((funct3 == HALF) || (funct3 == HALF_U)) && offset[0]) ||
                         ((funct3 == WORD) && (offset != 2'b00));
`else
        misalign_fault = 1'b0;
`endif
    end

endmodule

// File: rtl/memory_mmio.sv
// Word-organised data RAM plus memory-mapped outport/inport registers, flash load and
// sticky fault capture. MEMORY_MMIO_MISALIGN_FAULT_EN turns misaligned accesses into faults.
module memory_mmio import memory_mmio_pkg::*; #(
    parameter int          WIDTH      = 32,
    parameter int          DEPTH      = 256,
    parameter int          N_OUTPORTS = 2,
    parameter int          N_INPORTS  = 2,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    memory_mmio_if.slave                  bus,
    input  logic                          fault_clr,
    input  logic [N_INPORTS*WIDTH-1:0]    inports,
    output logic [N_OUTPORTS*WIDTH-1:0]   outports,
    output logic                          fault,
    output logic [WIDTH-1:0]              fault_addr
);

    localparam int               AW        = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] RAM_BYTES = WIDTH'(4 * DEPTH);
    localparam logic [WIDTH-1:0] OUT_BYTES = WIDTH'(4 * N_OUTPORTS);
    localparam logic [WIDTH-1:0] IN_BYTES  = WIDTH'(4 * N_INPORTS);
    localparam logic [WIDTH-1:0] IN_OFF    = WIDTH'(INPORT_OFFSET);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] out_regs [N_OUTPORTS];

    region_t          region;
    logic [WIDTH-1:0] io_off;
    logic [WIDTH-1:0] in_off;
    logic [3:0]       out_idx;
    logic [3:0]       in_idx;
    logic [AW-1:0]    ram_idx;
    logic [WIDTH-1:0] src_word;

    logic [3:0]       byte_en;
    logic [31:0]      wr_lanes;
    logic [31:0]      rd_ext;
    logic             fn_bad;
    logic             misalign_fault;

    logic             access;
    logic             bad;
    logic             load_req;
    logic             store_ok;
    logic             fault_ev;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_comb begin
        io_off  = bus.addr - IO_BASE;
        in_off  = io_off - IN_OFF;
        ram_idx = bus.addr[AW+1:2];
        out_idx = io_off[5:2];
        in_idx  = in_off[5:2];
        if (bus.addr < RAM_BYTES)
            region = REGION_RAM;
        else if ((bus.addr >= IO_BASE) && (io_off < OUT_BYTES))
            region = REGION_OUT;
        else if ((bus.addr >= IO_BASE) && (io_off >= IN_OFF) && (in_off < IN_BYTES))
            region = REGION_IN;
        else
            region = REGION_NONE;
    end

    // Inports are sampled combinationally so a load returns their value at the request edge.
    always_comb begin
        src_word = '0;
        case (region)
            REGION_RAM: src_word = mem[ram_idx];
            REGION_OUT: begin
                for (int i = 0; i < N_OUTPORTS; i++)
                    if (out_idx == 4'(i)) src_word = out_regs[i];
            end
            REGION_IN: begin
                for (int j = 0; j < N_INPORTS; j++)
                    if (in_idx == 4'(j)) src_word = inports[j*WIDTH +: WIDTH];
            end
            default: src_word = '0;
        endcase
    end

    mem_lane_align u_align (
        .funct3         (bus.funct3),
        .offset         (bus.addr[1:0]),
        .wr_data        (bus.wr_data),
        .rd_word        (src_word),
        .byte_en        (byte_en),
        .wr_lanes       (wr_lanes),
        .rd_ext         (rd_ext),
        .fn_bad         (fn_bad),
        .misalign_fault (misalign_fault)
    );

    // Flash takes the cycle; reset blocks normal accesses but not flash.
    assign access   = bus.en & ~bus.flash_en & rst;
    assign bad      = fn_bad | misalign_fault;
    assign load_req = access & ~bus.wren;
    assign store_ok = access & bus.wren & ~bad;
    assign fault_ev = access & (bad | (region == REGION_NONE) |
                                (bus.wren & (region == REGION_IN)));
    assign load_val = (bad || (region == REGION_NONE)) ? '0 : rd_ext;

    always_ff @(posedge clk) begin
        if (bus.flash_en) begin
            if (region == REGION_RAM) mem[ram_idx] <= bus.wr_data;
        end else if (store_ok && (region == REGION_RAM)) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) mem[ram_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_OUTPORTS; i++) out_regs[i] <= '0;
        end else if (store_ok && (region == REGION_OUT)) begin
            for (int i = 0; i < N_OUTPORTS; i++)
                if (out_idx == 4'(i))
                    for (int b = 0; b < 4; b++)
                        if (byte_en[b]) out_regs[i][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
    end

    always_comb begin
        outports = '0;
        for (int i = 0; i < N_OUTPORTS; i++) outports[i*WIDTH +: WIDTH] = out_regs[i];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= load_req;
            if (load_req) rd_data_q <= load_val;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    // A clear coinciding with a new fault re-arms the address capture for that fault.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (fault_ev) begin
            fault <= 1'b1;
            if (!fault || fault_clr) fault_addr <= bus.addr;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_mmio.sv
// Scoreboard bench for memory_mmio: byte-addressed reference model, directed plan plus random traffic.
module tb_memory_mmio;
    import memory_mmio_pkg::*;

    localparam int          DEPTH = 256;
    localparam int          N_OUT = 2;
    localparam int          N_IN  = 2;
    localparam logic [31:0] IOB   = 32'hFFFF_FF00;

    logic                clk = 1'b0;
    logic                rst;
    logic                fault_clr;
    logic [N_IN*32-1:0]  in_vec;
    logic [N_OUT*32-1:0] out_vec;
    logic                fault;
    logic [31:0]         fault_addr;

    memory_mmio_if #(.WIDTH(32)) bus();

    memory_mmio #(
        .WIDTH(32), .DEPTH(DEPTH), .N_OUTPORTS(N_OUT), .N_INPORTS(N_IN), .IO_BASE(IOB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .fault_clr(fault_clr),
        .inports(in_vec), .outports(out_vec), .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t q[$];

    logic [7:0]         ram_m [4*DEPTH];
    logic [31:0]        out_m [N_OUT];
    logic               fault_m;
    logic [31:0]        fa_m;
    logic [N_IN*32-1:0] nxt_in;
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        if (a < 4*DEPTH) return 0;
        if (a >= IOB && (a - IOB) < 4*N_OUT) return 1;
        if (a >= IOB + 32'h80 && (a - IOB - 32'h80) < 4*N_IN) return 2;
        return 3;
    endfunction

    function automatic int acc_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        logic [31:0] w;
        int o;
        o = int'(a % 4);
        case (region_of(a))
            0:       return ram_m[a];
            1: begin w = out_m[(a - IOB) >> 2]; return w[8*o +: 8]; end
            2: begin w = in_vec[32*((a - IOB - 32'h80) >> 2) +: 32]; return w[8*o +: 8]; end
            default: return 8'h00;
        endcase
    endfunction

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w;
        int i;
        if (region_of(a) == 0) ram_m[a] = b;
        else if (region_of(a) == 1) begin
            i = int'((a - IOB) >> 2);
            w = out_m[i];
            w[8*int'(a % 4) +: 8] = b;
            out_m[i] = w;
        end
    endtask

    task automatic model_access(input logic wr, input logic [31:0] a_in, input logic [31:0] d,
                                input logic [2:0] f, output logic ev, output logic [31:0] val);
        int sz;
        int r;
        logic [31:0] a;
        a = a_in;
        sz = acc_size(f);
        r = region_of(a);
        ev = 1'b0;
        val = '0;
        if (sz == 0) ev = 1'b1;
        else if (sz > 1 && (a % sz) != 0) begin
`ifdef MEMORY_MMIO_MISALIGN_FAULT_EN
            ev = 1'b1;
`else
            a = a - (a % sz);
`endif
        end
        if (!ev) begin
            if (wr) begin
                if (r >= 2) ev = 1'b1;
                else for (int k = 0; k < sz; k++) wr_byte(a + k, 8'(d >> (8*k)));
            end else if (r == 3) begin
                ev = 1'b1;
            end else begin
                for (int k = 0; k < sz; k++) val = val | (32'(rd_byte(a + k)) << (8*k));
                if (f == 3'b000) val = {{24{val[7]}}, val[7:0]};
                if (f == 3'b001) val = {{16{val[15]}}, val[15:0]};
            end
        end
    endtask

    task automatic op(input logic r, input logic flash, input logic en, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      input logic clr, input bit use_k, input logic [31:0] k);
        logic ev;
        logic [31:0] val;
        @(negedge clk);
        rst = r; bus.flash_en = flash; bus.en = en; bus.wren = wr; bus.addr = a;
        bus.wr_data = d; bus.funct3 = funct3_t'(f); fault_clr = clr; in_vec = nxt_in;
        if (flash && a < 4*DEPTH)
            for (int b = 0; b < 4; b++) ram_m[(a & ~32'h3) + b] = 8'(d >> (8*b));
        if (!r) begin
            fault_m = 1'b0; fa_m = '0;
            for (int i = 0; i < N_OUT; i++) out_m[i] = '0;
        end else begin
            ev = 1'b0;
            if (!flash && en) begin
                model_access(wr, a, d, f, ev, val);
                if (!wr) q.push_back('{data: (use_k ? k : val), due: cyc + 1});
            end
            if (ev) begin
                if (!fault_m || clr) fa_m = a;
                fault_m = 1'b1;
            end else if (clr) fault_m = 1'b0;
        end
    endtask

    task automatic idle(input logic clr);
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010, clr, 1'b0, 32'h0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic clr);
        op(1'b1, 1'b0, 1'b1, 1'b1, a, d, f, clr, 1'b0, 32'h0);
    endtask

    task automatic ld_k(input logic [31:0] a, input logic [2:0] f, input logic [31:0] k);
        op(1'b1, 1'b0, 1'b1, 1'b0, a, 32'h0, f, 1'b0, 1'b1, k);
    endtask

    // Monitor: pops the scoreboard on each rd_valid and tracks fault/outport state every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.rd_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("rd_latency", 32'(cyc), 32'(e.due));
                    chk("rd_data", bus.rd_data, e.data);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++; errors++;
                $display("FAIL rd_valid_missing: got 0 expected 1 for data %h (cycle %0d)", e.data, cyc);
            end
            chk("fault", 32'(fault), 32'(fault_m));
            chk("fault_addr", fault_addr, fa_m);
            for (int i = 0; i < N_OUT; i++) chk("outport", out_vec[32*i +: 32], out_m[i]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int sel;
        rst = 1'b0; bus.en = 1'b0; bus.wren = 1'b0; bus.flash_en = 1'b0;
        bus.addr = '0; bus.wr_data = '0; bus.funct3 = WORD; fault_clr = 1'b0;
        in_vec = '0; nxt_in = '0;
        fault_m = 1'b0; fa_m = '0;
        for (int i = 0; i < N_OUT; i++) out_m[i] = '0;
        for (int i = 0; i < 4*DEPTH; i++) ram_m[i] = 8'h00;

        // Test 1: flash while in reset, then word loads
        for (int w = 0; w < 16; w++) op(1'b0, 1'b1, 1'b0, 1'b0, 32'(4*w), 32'h0, 3'b010, 1'b0, 1'b0, 32'h0);
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd12345, 3'b010, 1'b0, 1'b0, 32'h0);
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 32'd678910, 3'b010, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("reset_rd_data", bus.rd_data, 32'h0);
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
        ld_k(32'd0, 3'b010, 32'd12345);
        ld_k(32'd4, 3'b010, 32'd678910);
        idle(1'b0); idle(1'b0);

        // Test 2: byte/half extraction and extension
        st(32'd8, 32'h8081_82F3, 3'b010, 1'b0);
        ld_k(32'd8, 3'b000, 32'hFFFF_FFF3);
        ld_k(32'd9, 3'b100, 32'h0000_0082);
        ld_k(32'd10, 3'b001, 32'hFFFF_8081);
        ld_k(32'd10, 3'b101, 32'h0000_8081);

        // Test 3: byte store into an existing word
        st(32'd12, 32'h1111_1111, 3'b010, 1'b0);
        st(32'd13, 32'h0000_00AA, 3'b000, 1'b0);
        ld_k(32'd12, 3'b010, 32'h1111_AA11);

        // Test 4: outport store, inport load
        st(IOB + 32'd4, 32'hDEAD_BEEF, 3'b010, 1'b0);
        idle(1'b0);
        chk("outport1", out_vec[63:32], 32'hDEAD_BEEF);
        chk("outport0", out_vec[31:0], 32'h0);
        ld_k(32'd4, 3'b010, 32'd678910);
        nxt_in = {32'h0, 32'h0000_00C3};
        ld_k(IOB + 32'h80, 3'b010, 32'h0000_00C3);
        idle(1'b0);

        // Test 5: sticky fault and clear interaction
        st(32'h0001_0000, 32'h1, 3'b010, 1'b0);
        st(32'h0002_0000, 32'h2, 3'b010, 1'b0);
        @(posedge clk); #1;
        chk("fault_first_addr", fault_addr, 32'h0001_0000);
        st(32'h0003_0000, 32'h3, 3'b010, 1'b1);
        @(posedge clk); #1;
        chk("fault_clr_new_addr", fault_addr, 32'h0003_0000);
        chk("fault_clr_new_flag", 32'(fault), 32'h1);
        idle(1'b1);
        @(posedge clk); #1;
        chk("fault_cleared", 32'(fault), 32'h0);

        // Test 6: misaligned word load
`ifdef MEMORY_MMIO_MISALIGN_FAULT_EN
        ld_k(32'd6, 3'b010, 32'h0);
        @(posedge clk); #1;
        chk("misalign_fault", 32'(fault), 32'h1);
        chk("misalign_fault_addr", fault_addr, 32'd6);
`else
        ld_k(32'd6, 3'b010, 32'd678910);
        @(posedge clk); #1;
        chk("misalign_nofault", 32'(fault), 32'h0);
`endif
        idle(1'b1);

        // Random traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: a = 32'($urandom_range(0, 63));
                4, 5:       a = IOB + 32'($urandom_range(0, 4*N_OUT - 1));
                6, 7:       a = IOB + 32'h80 + 32'($urandom_range(0, 4*N_IN - 1));
                8:          a = 32'h0001_0000 + 32'($urandom_range(0, 255));
                default:    a = IOB + 32'h40 + 32'($urandom_range(0, 15));
            endcase
            f = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                            : ((sel % 2 == 0) ? 3'b010 : 3'($urandom_range(0, 5)));
            nxt_in = {$urandom, $urandom};
            op(($urandom_range(0, 39) != 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
               a, $urandom, f, ($urandom_range(0, 7) == 0), 1'b0, 32'h0);
        end
        idle(1'b0); idle(1'b0); idle(1'b0);
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
